// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, single-stall branch
// resolution with IF/ID squash, and multi-cycle mult/div occupancy, plus a stall counter.
module hazard_sequencer #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRegisterRt,
  input  logic [4:0]       IFIDRegisterRs,
  input  logic [4:0]       IFIDRegisterRt,
  input  logic             ControlBranch,
  input  logic             BranchTaken,
  input  logic             MduStart,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             controlmux,
  output logic             IFIDflush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {StRun, StBrEx, StMduWait} state_e;

  localparam logic [7:0] MduLoad = 8'(MDU_LATENCY - 1);

  state_e           state_q, state_d;
  logic [7:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // $0 is hardwired to zero, so a load targeting it can never feed a dependent.
  assign load_use = IDEXMemRead && (IDEXRegisterRt != 5'd0) &&
                    ((IDEXRegisterRt == IFIDRegisterRs) || (IDEXRegisterRt == IFIDRegisterRt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      mdu_cnt_q <= 8'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    unique case (state_q)
      StRun: begin
        if (load_use) begin
          state_d = StRun;
        end else if (ControlBranch) begin
          state_d = StBrEx;
        end else if (MduStart) begin
          state_d   = StMduWait;
          mdu_cnt_d = MduLoad;
        end
      end
      StBrEx: state_d = StRun;
      StMduWait: begin
        if (mdu_cnt_q != 8'd0) begin
          mdu_cnt_d = mdu_cnt_q - 8'd1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    PCwrite    = 1'b0;
    IFIDwrite  = 1'b0;
    controlmux = 1'b0;
    IFIDflush  = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            PCwrite    = 1'b1;
            IFIDwrite  = 1'b1;
            controlmux = 1'b1;
          end else if (ControlBranch) begin
            PCwrite   = 1'b1;
            IFIDwrite = 1'b1;
          end
        end
        StBrEx: begin
          busy = 1'b1;
          if (BranchTaken) begin
            IFIDflush  = 1'b1;
            controlmux = 1'b1;
          end
        end
        StMduWait: begin
          busy       = 1'b1;
          PCwrite    = 1'b1;
          IFIDwrite  = 1'b1;
          controlmux = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating: stops at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (PCwrite && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = reset ? '0 : cnt_q;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Sequential stall/flush controller for the 5-stage MIPS pipeline. It replaces purely combinational stall generation with a small state machine that handles three cases:
- load-use hazards
- single-stall branch resolution with IF/ID squash on taken branches
- multi-cycle multiply/divide occupancy

It drives the PC write-hold, the IF/ID hold/flush, and the ID/EX control-bubble mux, and counts stall cycles for performance reporting.

## Interface
Parameters:
- MDU_LATENCY, 32, number of stall cycles after a mult/div enters EX (legal range 1..255)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- IDEXMemRead  input  1  instruction in EX is a load
- IDEXRegisterRt  input  5  destination rt of the instruction in EX
- IFIDRegisterRs  input  5  rs of the instruction in ID
- IFIDRegisterRt  input  5  rt of the instruction in ID
- ControlBranch  input  1  instruction in ID is a beq/bne
- BranchTaken  input  1  branch in EX resolved taken; sampled only in state BR_EX
- MduStart  input  1  instruction in ID is mult/div
- PCwrite  output  1  1 = hold PC, 0 = PC updates
- IFIDwrite  output  1  1 = hold IF/ID, 0 = IF/ID loads
- controlmux  output  1  1 = zero control bits into ID/EX (bubble)
- IFIDflush  output  1  1 = clear IF/ID to NOP at the next edge
- busy  output  1  state is not RUN
- stall_count  output  CNT_W  cycles with PCwrite=1 since reset, saturating

## Operation
- States: RUN, BR_EX, MDU_WAIT. A down-counter mdu_cnt has width 8.
- Outputs are combinational from the current state and current inputs. State, mdu_cnt and stall_count are registered.
- RUN, evaluated in strict priority order:
  1. Load-use: IDEXMemRead=1, IDEXRegisterRt!=0, and IDEXRegisterRt equals IFIDRegisterRs or IFIDRegisterRt.
     - Outputs: PCwrite=1, IFIDwrite=1, controlmux=1, IFIDflush=0.
     - Next state: RUN.
  2. ControlBranch=1.
     - Outputs: PCwrite=1, IFIDwrite=1, controlmux=0. The branch advances to EX.
     - Next state: BR_EX.
  3. MduStart=1.
     - Outputs: all 0. The mult/div advances to EX.
     - Load mdu_cnt=MDU_LATENCY-1. Next state: MDU_WAIT.
  4. Otherwise all outputs 0; stay in RUN.
- BR_EX (branch in EX):
  - BranchTaken=1: PCwrite=0 (PC loads target), IFIDflush=1, IFIDwrite=0, controlmux=1.
  - BranchTaken=0: all outputs 0; the held sequential instruction proceeds.
  - Next state: RUN, unconditionally.
- MDU_WAIT:
  - Outputs: PCwrite=1, IFIDwrite=1, controlmux=1, IFIDflush=0.
  - If mdu_cnt!=0, decrement it; else next state is RUN.
  - MduStart, ControlBranch and load-use inputs are ignored; the ID instruction is held and is re-evaluated in RUN.
- stall_count increments on every cycle with PCwrite=1 and reset=0. It holds at 2^CNT_W-1.
- busy=1 in BR_EX and MDU_WAIT.
- Register $0 never creates a load-use hazard.

## Timing
- Reset, effective at the edge where reset=1:
  - state=RUN, mdu_cnt=0, stall_count=0.
  - While reset=1, every output is forced to 0 regardless of inputs.
  - Reset mid-operation (in BR_EX or MDU_WAIT) abandons the operation; there is no pending stall afterwards.
- Load-use costs exactly 1 bubble cycle. The next cycle sees the bubble in EX, so no repeat stall occurs.
- Branch costs exactly 1 hold cycle in RUN plus the resolve cycle in BR_EX.
  - Taken: one instruction squashed.
  - Not taken: zero squashed.
- Mult/div: MduStart in RUN at cycle T. MDU_WAIT occupies cycles T+1..T+MDU_LATENCY with stall asserted. RUN resumes at T+MDU_LATENCY+1.
- Simultaneous load-use and ControlBranch in RUN: the load-use stall wins this cycle; the branch is taken up next cycle.
- Simultaneous ControlBranch and MduStart cannot occur (same ID slot). If both are asserted, ControlBranch wins.

## Test plan
- Reset: assert reset for 2 cycles with all inputs 1 -> all outputs 0, stall_count=0, busy=0.
- Load-use, then $0:
  - IDEXMemRead=1, IDEXRegisterRt=5, IFIDRegisterRs=5 -> PCwrite=IFIDwrite=controlmux=1 for 1 cycle, stall_count=1.
  - Repeat with Rt=0 -> no stall.
- Branch taken: ControlBranch=1 in RUN; next cycle BranchTaken=1 -> cycle 1: PCwrite=1, controlmux=0; cycle 2: IFIDflush=1, controlmux=1, PCwrite=0; cycle 3: RUN, busy=0.
- Branch not taken: same sequence with BranchTaken=0 -> cycle 2 all outputs 0, IFIDflush never asserted.
- MDU with MDU_LATENCY=4: MduStart pulse at T -> PCwrite=1 exactly at T+1..T+4, RUN at T+5, stall_count=4. Reset asserted at T+2 -> outputs 0 from T+2, RUN, no further stall.
- Saturation with CNT_W=4: hold MDU_WAIT with MDU_LATENCY=20 -> stall_count stops at 15.
